// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (8N1, LSB first) feeding a
// show-ahead FIFO with sticky frame-error and overrun status.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1
// (even parity bit between the data and stop bits); ports are identical.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 25_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [7:0]                    rd_data,
   output logic                          rx_empty,
   output logic                          rx_full,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = $clog2(DIV + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic             rx_meta_reg, rx_sync_reg;
   logic [DIV_W-1:0] tick_cnt_reg;
   logic             tick_reg;
   state_t           state_reg;
   logic [3:0]       sample_cnt_reg;
   logic [2:0]       bit_idx_reg;
   logic [7:0]       shift_reg;
   logic             push_req_reg;
   logic [7:0]       push_byte_reg;
   logic             ferr_evt_reg;
   logic             parity_ok;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
   logic             do_pop, do_push, ovf_evt;

   // Two-flop synchronizer; presets to idle-high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
      end
   end

   // Free-running 16x oversampling tick, one cycle wide every DIV clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_reg <= '0;
         tick_reg     <= 1'b0;
      end else if (tick_cnt_reg == DIV_W'(DIV - 1)) begin
         tick_cnt_reg <= '0;
         tick_reg     <= 1'b1;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + 1'b1;
         tick_reg     <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_bit_reg;
   // Even parity: the parity bit must equal the XOR of the eight data bits
   assign parity_ok = (parity_bit_reg == ^shift_reg);
`else
   assign parity_ok = 1'b1;
`endif

   // Deframing FSM; push/error requests are registered and act one cycle after the stop sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         sample_cnt_reg <= '0;
         bit_idx_reg    <= '0;
         shift_reg      <= '0;
         push_req_reg   <= 1'b0;
         push_byte_reg  <= '0;
         ferr_evt_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit_reg <= 1'b0;
`endif
      end else begin
         push_req_reg <= 1'b0;
         ferr_evt_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (!rx_sync_reg) begin
                  state_reg      <= S_START;
                  sample_cnt_reg <= '0;
               end
            end
            S_START: begin
               if (tick_reg) begin
                  if (sample_cnt_reg == 4'd7) begin
                     sample_cnt_reg <= '0;
                     bit_idx_reg    <= '0;
                     state_reg      <= rx_sync_reg ? S_IDLE : S_DATA;
                  end else begin
                     sample_cnt_reg <= sample_cnt_reg + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (tick_reg) begin
                  if (sample_cnt_reg == 4'd15) begin
                     sample_cnt_reg <= '0;
                     shift_reg      <= {rx_sync_reg, shift_reg[7:1]};
                     bit_idx_reg    <= bit_idx_reg + 3'd1;
                     if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_reg <= S_PARITY;
`else
                        state_reg <= S_STOP;
`endif
                     end
                  end else begin
                     sample_cnt_reg <= sample_cnt_reg + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick_reg) begin
                  if (sample_cnt_reg == 4'd15) begin
                     sample_cnt_reg <= '0;
                     parity_bit_reg <= rx_sync_reg;
                     state_reg      <= S_STOP;
                  end else begin
                     sample_cnt_reg <= sample_cnt_reg + 4'd1;
                  end
               end
            end
`endif
            S_STOP: begin
               if (tick_reg) begin
                  if (sample_cnt_reg == 4'd15) begin
                     sample_cnt_reg <= '0;
                     state_reg      <= S_IDLE;
                     if (rx_sync_reg && parity_ok) begin
                        push_req_reg  <= 1'b1;
                        push_byte_reg <= shift_reg;
                     end else begin
                        ferr_evt_reg  <= 1'b1;
                     end
                  end else begin
                     sample_cnt_reg <= sample_cnt_reg + 4'd1;
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // FIFO status derives from the pointer difference; the extra MSB separates full from empty
   assign rx_count = wr_ptr_reg - rd_ptr_reg;
   assign rx_empty = (rx_count == '0);
   assign rx_full  = (rx_count == (AW + 1)'(FIFO_DEPTH));
   assign rd_data  = rx_empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

   // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds when popped together
   assign do_pop  = rd_en && !rx_empty;
   assign do_push = push_req_reg && (!rx_full || do_pop);
   assign ovf_evt = push_req_reg && rx_full && !do_pop;

   // Storage array, write-only port on the clock edge
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg[AW-1:0]] <= push_byte_reg;
   end

   // Pointer update; reset empties the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Sticky error flags; a new event in the same cycle as clr_err keeps the flag set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (ferr_evt_reg)  frame_err <= 1'b1;
         else if (clr_err)  frame_err <= 1'b0;
         if (ovf_evt)       overrun   <= 1'b1;
         else if (clr_err)  overrun   <= 1'b0;
      end
   end

endmodule
